// File: rtl/nand_page_read_seq_pkg.sv
// nand_page_read_seq_pkg: shared NAND command codes, sequencer states, default timings
// and the address-cycle byte selector.
package nand_page_read_seq_pkg;
    localparam logic [7:0] CMD_READ1 = 8'h00;
    localparam logic [7:0] CMD_READ2 = 8'h30;

    localparam int          DEF_COL_CYCLES = 2;
    localparam int          DEF_ROW_CYCLES = 3;
    localparam logic [15:0] DEF_TWB        = 16'd5;
    localparam logic [15:0] DEF_TRP        = 16'd2;
    localparam logic [15:0] DEF_TREH       = 16'd1;
    localparam logic [15:0] DEF_TIMEOUT    = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE, CMD1, ADDR, CMD2, WB, BUSY, RD_LOW, RD_HIGH, DONE
    } state_t;

    // Column bytes go out first (LSB first), then row bytes (LSB first).
    function automatic logic [7:0] addr_byte(input logic [15:0] col, input logic [23:0] row,
                                             input logic [2:0] idx, input int col_cycles);
        int r;
        r = int'(idx) - col_cycles;
        return r < 0 ? (idx[0] ? col[15:8] : col[7:0]) :
               r == 0 ? row[7:0] : r == 1 ? row[15:8] : row[23:16];
    endfunction
endpackage

// File: rtl/nand_page_read_seq_rb_sync.sv
// nand_rb_sync: two-flop synchroniser for the NAND ready/busy pin, idling at ready.
module nand_rb_sync (
    input  logic CLK,
    input  logic RSTn,
    input  logic RB,
    output logic rb_ready
);
    logic meta;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) {rb_ready, meta} <= 2'b11;
        else       {rb_ready, meta} <= {meta, RB};
    end
endmodule

// File: rtl/nand_page_read_seq.sv
// nand_page_read_seq: issues 00h / address / 30h through the latch-stage handshakes,
// waits tWB and R/B ready, then strobes REn to read Byte_num bytes.
module nand_page_read_seq
    import nand_page_read_seq_pkg::*;
#(
    parameter int          COL_CYCLES  = DEF_COL_CYCLES,
    parameter int          ROW_CYCLES  = DEF_ROW_CYCLES,
    parameter logic [15:0] tWB_cnt     = DEF_TWB,
    parameter logic [15:0] tRP_cnt     = DEF_TRP,
    parameter logic [15:0] tREH_cnt    = DEF_TREH,
    parameter logic [15:0] TIMEOUT_cnt = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req,
    input  logic [15:0] Col_addr,
    input  logic [23:0] Row_addr,
    input  logic [11:0] Byte_num,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        Cmd_start,
    input  logic        Cmd_over,
    output logic        Addr_start,
    input  logic        Addr_over,
    output logic [7:0]  DQ_out,
    input  logic        RB,
    output logic        REn,
    input  logic [7:0]  DQ_in,
    output logic [7:0]  Rd_data,
    output logic        Rd_valid
);
    localparam logic [2:0] LAST_IDX = 3'(COL_CYCLES + ROW_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, col_q;
    logic [23:0] row_q;
    logic [11:0] num_q, bcnt;
    logic [2:0]  idx;
    logic        started, rb_ready, in_hs, acc, cap, timeout;

    nand_rb_sync u_rb_sync (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .RB       (RB),
        .rb_ready (rb_ready)
    );

    // An Over only counts once our Start for the current item has gone out.
    always_comb begin
        in_hs   = state == CMD1 || state == ADDR || state == CMD2;
        acc     = in_hs && started && (state == ADDR ? Addr_over : Cmd_over);
        cap     = state == RD_LOW && cnt == tRP_cnt;
        timeout = state == BUSY && !rb_ready && cnt == TIMEOUT_cnt - 16'd1;
        state_n = state;
        case (state)
            IDLE:    state_n = Req ? CMD1 : IDLE;
            CMD1:    state_n = acc ? ADDR : CMD1;
            ADDR:    state_n = acc && idx == LAST_IDX ? CMD2 : ADDR;
            CMD2:    state_n = acc ? WB : CMD2;
            WB:      state_n = cnt == tWB_cnt ? BUSY : WB;
            BUSY:    state_n = rb_ready ? (num_q == '0 ? DONE : RD_LOW) : timeout ? DONE : BUSY;
            RD_LOW:  state_n = cap ? RD_HIGH : RD_LOW;
            RD_HIGH: state_n = cnt == tREH_cnt ? (bcnt == num_q ? DONE : RD_LOW) : RD_HIGH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            started    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            num_q      <= '0;
            bcnt       <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            Cmd_start  <= 1'b0;
            Addr_start <= 1'b0;
            DQ_out     <= '0;
            REn        <= 1'b1;
            Rd_data    <= '0;
            Rd_valid   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= state_n != state ? '0 : cnt + 16'd1;
            started <= in_hs && !acc;
            idx     <= state == IDLE ? '0 : (state == ADDR && acc) ? idx + 3'd1 : idx;
            bcnt    <= state == IDLE ? '0 : cap ? bcnt + 12'd1 : bcnt;
            if (state == IDLE && Req) begin
                col_q <= Col_addr;
                row_q <= Row_addr;
                num_q <= Byte_num;
            end
            Busy       <= state != IDLE;
            Done       <= state == DONE;
            Err        <= (state == IDLE && Req) ? 1'b0 : timeout ? 1'b1 : Err;
            Cmd_start  <= (state == CMD1 || state == CMD2) && !started;
            Addr_start <= state == ADDR && !started;
            DQ_out     <= state == CMD1 ? CMD_READ1 : state == CMD2 ? CMD_READ2 :
                          state == ADDR ? addr_byte(col_q, row_q, idx, COL_CYCLES) : DQ_out;
            REn        <= state != RD_LOW;
            Rd_valid   <= cap;
            if (cap) Rd_data <= DQ_in;
        end
    end
endmodule

// File: tb/tb_nand_page_read_seq.sv
// tb_nand_page_read_seq: scoreboard bench with a latch-stage Over model, an R/B model
// and a NAND data model feeding DQ_in on each REn fall.
module tb_nand_page_read_seq;
    localparam logic [15:0] TO = 16'd100;

    logic        CLK = 1'b0, RSTn = 1'b0, Req = 1'b0;
    logic [15:0] Col_addr = '0;
    logic [23:0] Row_addr = '0;
    logic [11:0] Byte_num = '0;
    logic        Busy, Done, Err, Cmd_start, Addr_start, REn, Rd_valid;
    logic [7:0]  DQ_out, Rd_data;
    logic        cmd_over_m = 1'b0, spur_over = 1'b0, Addr_over = 1'b0, RB = 1'b1;
    logic [7:0]  DQ_in = '0;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] exp_dq[$], exp_rd[$];
    int rv_cyc[$];
    logic [7:0] rd_model[16];
    int rk = 0, n_cs = 0, n_as = 0, n_ren_low = 0, n_done = 0;
    int cd_c = 0, cd_a = 0, rb_cd = 0, rb_low_len = 10;
    int rb_rise_cyc = 0, ren_fall_cyc = 0, over2_cyc = 0, done_cyc = 0;
    int e, kk, cs0, d0;
    bit rb_hold = 0, ren_prev = 1, fall_pending = 0;
    logic [7:0] last_dq = '0, last_adq = '0;

    nand_page_read_seq #(.TIMEOUT_cnt(TO)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Req        (Req),
        .Col_addr   (Col_addr),
        .Row_addr   (Row_addr),
        .Byte_num   (Byte_num),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .Cmd_start  (Cmd_start),
        .Cmd_over   (cmd_over_m | spur_over),
        .Addr_start (Addr_start),
        .Addr_over  (Addr_over),
        .DQ_out     (DQ_out),
        .RB         (RB),
        .REn        (REn),
        .DQ_in      (DQ_in),
        .Rd_data    (Rd_data),
        .Rd_valid   (Rd_valid)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Latch-stage, R/B and NAND data models plus scoreboard pops, all at the falling edge.
    initial forever begin
        @(negedge CLK);
        cmd_over_m = 1'b0;
        Addr_over  = 1'b0;
        if (Cmd_start) begin
            e = 256;
            if (exp_dq.size() > 0) e = exp_dq.pop_front();
            check("dq_seq_cmd", DQ_out, e);
            n_cs++;
            cd_c = 4;
            last_dq = DQ_out;
            if (DQ_out == 8'h30) begin
                rb_cd = rb_low_len;
                RB = 1'b0;
            end
        end else if (cd_c > 0) begin
            cd_c--;
            if (cd_c == 0) begin
                cmd_over_m = 1'b1;
                check("cmd_dq_stable", DQ_out, last_dq);
                if (last_dq == 8'h30) over2_cyc = cyc;
            end
        end
        if (Addr_start) begin
            e = 256;
            if (exp_dq.size() > 0) e = exp_dq.pop_front();
            check("dq_seq_addr", DQ_out, e);
            n_as++;
            cd_a = 4;
            last_adq = DQ_out;
        end else if (cd_a > 0) begin
            cd_a--;
            if (cd_a == 0) begin
                Addr_over = 1'b1;
                check("addr_dq_stable", DQ_out, last_adq);
            end
        end
        if (rb_cd > 0 && !rb_hold) begin
            rb_cd--;
            if (rb_cd == 0) begin
                RB = 1'b1;
                rb_rise_cyc = cyc;
                fall_pending = 1;
            end
        end
        if (!REn && ren_prev) begin
            DQ_in = rd_model[rk % 16];
            rk++;
            if (fall_pending) begin
                ren_fall_cyc = cyc;
                fall_pending = 0;
            end
        end
        ren_prev = REn;
        if (!REn) n_ren_low++;
        if (Rd_valid) begin
            e = 256;
            if (exp_rd.size() > 0) e = exp_rd.pop_front();
            check("rd_data", Rd_data, e);
            rv_cyc.push_back(cyc);
        end
        if (Done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic start_op(input logic [15:0] c, input logic [23:0] r, input logic [11:0] n,
                            input int rbl, input int nrd);
        rb_low_len = rbl;
        exp_dq.push_back(8'h00);
        exp_dq.push_back(c[7:0]);
        exp_dq.push_back(c[15:8]);
        exp_dq.push_back(r[7:0]);
        exp_dq.push_back(r[15:8]);
        exp_dq.push_back(r[23:16]);
        exp_dq.push_back(8'h30);
        for (int i = 0; i < nrd; i++) exp_rd.push_back(rd_model[(rk + i) % 16]);
        Col_addr = c;
        Row_addr = r;
        Byte_num = n;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        check("err_clear", Err, 0);
        tick();
        check("busy_rise", Busy, 1);
    endtask

    task automatic run_read(input logic [15:0] c, input logic [23:0] r, input logic [11:0] n,
                            input int rbl, input logic exp_err);
        int cs_0, as_0, rl_0, rv_0, k, nrd;
        cs_0 = n_cs;
        as_0 = n_as;
        rl_0 = n_ren_low;
        rv_0 = rv_cyc.size();
        nrd  = exp_err ? 0 : int'(n);
        k    = 0;
        start_op(c, r, n, rbl, nrd);
        while (!Done && k < 3000) begin
            tick();
            k++;
        end
        check("done_seen", Done, 1);
        check("err_at_done", Err, exp_err);
        check("busy_at_done", Busy, 1);
        tick();
        check("done_pulse", Done, 0);
        check("busy_fall", Busy, 0);
        check("cmd_starts", n_cs - cs_0, 2);
        check("addr_starts", n_as - as_0, 5);
        check("ren_low_cycles", n_ren_low - rl_0, 3 * nrd);
        check("dq_left", exp_dq.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        for (int i = rv_0 + 1; i < rv_cyc.size(); i++)
            check("rv_spacing", rv_cyc[i] - rv_cyc[i-1], 5);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_model[i] = 8'hAA + 8'(i * 17);
        tick(3);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_err", Err, 0);
        check("rst_cmd_start", Cmd_start, 0);
        check("rst_addr_start", Addr_start, 0);
        check("rst_dq_out", DQ_out, 0);
        check("rst_ren", REn, 1);
        check("rst_rd_data", Rd_data, 0);
        check("rst_rd_valid", Rd_valid, 0);
        RSTn = 1'b1;
        tick(2);

        run_read(16'h0123, 24'h045678, 12'd4, 50, 1'b0);
        check("ren_wait", ren_fall_cyc - rb_rise_cyc, 4);
        tick(3);

        run_read(16'h5A5A, 24'h00C3C3, 12'd0, 10, 1'b0);
        check("zero_done_lat", done_cyc - rb_rise_cyc, 4);
        tick(3);

        rb_hold = 1;
        run_read(16'h1111, 24'h222222, 12'd5, 3, 1'b1);
        check("timeout_cycles", done_cyc - over2_cyc, int'(TO) + 8);
        rb_hold = 0;
        tick(6);

        cs0 = n_cs;
        spur_over = 1'b1;
        tick();
        spur_over = 1'b0;
        tick(2);
        check("idle_busy", Busy, 0);
        check("idle_cmd_start", n_cs, cs0);
        fork
            run_read(16'hBEEF, 24'h123456, 12'd2, 8, 1'b0);
            begin
                kk = 0;
                while (!Addr_start && kk < 200) begin
                    tick();
                    kk++;
                end
                check("addr_seen", Addr_start, 1);
                Req = 1'b1;
                Col_addr = 16'hFFFF;
                Row_addr = 24'hFFFFFF;
                Byte_num = 12'd7;
                tick();
                Req = 1'b0;
            end
        join
        tick(3);

        d0 = n_done;
        start_op(16'h0F0F, 24'h00A0B0, 12'd4, 10, 4);
        kk = 0;
        while (REn && kk < 500) begin
            tick();
            kk++;
        end
        check("ren_low_seen", REn, 0);
        RSTn = 1'b0;
        #1;
        check("rst_mid_ren", REn, 1);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_valid", Rd_valid, 0);
        tick(2);
        RSTn = 1'b1;
        exp_rd.delete();
        check("rst_dq_left", exp_dq.size(), 0);
        tick(10);
        check("rst_no_done", n_done - d0, 0);
        run_read(16'h0123, 24'h045678, 12'd3, 20, 1'b0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
